// File: rtl/memfifo_pkg.sv
// rtl/memfifo_pkg.sv - shared state encoding and defaults for the USB packet scheduler
package memfifo_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_ARM  = 2'd2,
    ST_WAIT = 2'd3
  } sched_state_e;

  localparam int PKTEND_TIMEOUT_DEF = 4096;
  localparam int WORD_W             = 128;
  localparam int HALF_W             = 16;
  localparam int HALVES             = WORD_W / HALF_W;

endpackage

// File: rtl/usb_word_unpack.sv
// rtl/usb_word_unpack.sv - 128-bit word to 16-bit halfword shift register, low halfword first
module usb_word_unpack
  import memfifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic [HALF_W-1:0] dout,
  output logic [2:0]        word_idx
);

  logic [WORD_W-1:0] wbuf_q, wbuf_d;
  logic [2:0]        idx_q, idx_d;

  // Load wins over shift so a refill on the last halfword starts the new word cleanly
  always_comb begin
    wbuf_d = wbuf_q;
    idx_d  = idx_q;
    if (load) begin
      wbuf_d = din;
      idx_d  = 3'd0;
    end else if (shift) begin
      wbuf_d = {{HALF_W{1'b0}}, wbuf_q[WORD_W-1:HALF_W]};
      idx_d  = idx_q + 3'd1;
    end
  end

  // Buffer and index registers; reset discards any partially sent word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf_q <= '0;
      idx_q  <= 3'd0;
    end else begin
      wbuf_q <= wbuf_d;
      idx_q  <= idx_d;
    end
  end

  assign dout     = wbuf_q[HALF_W-1:0];
  assign word_idx = idx_q;

endmodule

// File: rtl/usb_pkt_sched.sv
// rtl/usb_pkt_sched.sv - FIFO to ezusb_io halfword scheduler with PKTEND packetization
module usb_pkt_sched
  import memfifo_pkg::*;
#(
  parameter int PKTEND_TIMEOUT = PKTEND_TIMEOUT_DEF
) (
  input  logic              ifclk,
  input  logic              reset,
  input  logic              enable,
  input  logic [15:0]       pkt_len,
  input  logic [WORD_W-1:0] fifo_do,
  input  logic              fifo_empty,
  output logic              fifo_rden,
  output logic [HALF_W-1:0] usb_di,
  output logic              usb_di_valid,
  input  logic              usb_di_ready,
  input  logic              pktend_n,
  output logic              pktend_arm,
  output logic [15:0]       pkt_cnt,
  output logic              timeout_err,
  output logic              busy
);

  localparam int TW = $clog2(PKTEND_TIMEOUT + 1);

  sched_state_e  state_q, state_d;
  logic          usb_di_valid_q, usb_di_valid_d;
  logic          fifo_rden_q, fifo_rden_d;
  logic          pktend_arm_q, pktend_arm_d;
  logic          timeout_err_q, timeout_err_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;
  logic [15:0]   in_cnt_q, in_cnt_d;
  logic [15:0]   len_q, len_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          load, shift;
  logic [2:0]    word_idx;
  logic          xfer, can_fetch, pkt_end;
  logic [15:0]   cur_len, in_cnt_inc;

  usb_word_unpack u_unpack (
    .clk      (ifclk),
    .rst      (reset),
    .load     (load),
    .shift    (shift),
    .din      (fifo_do),
    .dout     (usb_di),
    .word_idx (word_idx)
  );

  // The first transfer of a packet uses the live pkt_len; later ones use the latched copy
  assign xfer       = usb_di_valid_q & usb_di_ready;
  assign cur_len    = (in_cnt_q == 16'd0) ? pkt_len : len_q;
  assign in_cnt_inc = in_cnt_q + 16'd1;
  assign pkt_end    = (cur_len != 16'd0) && (in_cnt_inc == cur_len);
  // Empty flag is stale in the pop cycle, so no fetch is attempted then
  assign can_fetch  = enable & ~fifo_empty & ~fifo_rden_q;

  // Next-state and output logic for the IDLE/SEND/ARM/WAIT scheduler
  always_comb begin
    state_d        = state_q;
    usb_di_valid_d = usb_di_valid_q;
    fifo_rden_d    = 1'b0;
    pktend_arm_d   = pktend_arm_q;
    timeout_err_d  = timeout_err_q;
    pkt_cnt_d      = pkt_cnt_q;
    in_cnt_d       = in_cnt_q;
    len_d          = len_q;
    tmo_d          = tmo_q;
    load           = 1'b0;
    shift          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_fetch) begin
          load           = 1'b1;
          fifo_rden_d    = 1'b1;
          usb_di_valid_d = 1'b1;
          state_d        = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          shift    = 1'b1;
          in_cnt_d = in_cnt_inc;
          if (in_cnt_q == 16'd0) len_d = pkt_len;
          if (pkt_end) begin
            usb_di_valid_d = 1'b0;
            state_d        = ST_ARM;
          end else if (word_idx == 3'(HALVES - 1)) begin
            if (can_fetch) begin
              load        = 1'b1;
              fifo_rden_d = 1'b1;
            end else begin
              usb_di_valid_d = 1'b0;
              state_d        = ST_IDLE;
            end
          end
        end
      end
      ST_ARM: begin
        pktend_arm_d = 1'b1;
        tmo_d        = '0;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (!pktend_n || (tmo_q == TW'(PKTEND_TIMEOUT - 1))) begin
          if (!pktend_n) pkt_cnt_d = pkt_cnt_q + 16'd1;
          else           timeout_err_d = 1'b1;
          pktend_arm_d = 1'b0;
          in_cnt_d     = 16'd0;
          // Leftover halfwords of a word split by the packet end go out next
          if (word_idx != 3'd0) begin
            usb_di_valid_d = 1'b1;
            state_d        = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge ifclk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      usb_di_valid_q <= 1'b0;
      fifo_rden_q    <= 1'b0;
      pktend_arm_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
      pkt_cnt_q      <= 16'd0;
      in_cnt_q       <= 16'd0;
      len_q          <= 16'd0;
      tmo_q          <= '0;
    end else begin
      state_q        <= state_d;
      usb_di_valid_q <= usb_di_valid_d;
      fifo_rden_q    <= fifo_rden_d;
      pktend_arm_q   <= pktend_arm_d;
      timeout_err_q  <= timeout_err_d;
      pkt_cnt_q      <= pkt_cnt_d;
      in_cnt_q       <= in_cnt_d;
      len_q          <= len_d;
      tmo_q          <= tmo_d;
    end
  end

  assign usb_di_valid = usb_di_valid_q;
  assign fifo_rden    = fifo_rden_q;
  assign pktend_arm   = pktend_arm_q;
  assign timeout_err  = timeout_err_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_pkt_sched.sv
// tb/tb_usb_pkt_sched.sv - directed self-checking bench for usb_pkt_sched
module tb_usb_pkt_sched;

  logic          ifclk = 1'b0;
  logic          reset;
  logic          enable;
  logic [15:0]   pkt_len;
  logic [127:0]  fifo_do;
  logic          fifo_empty;
  logic          fifo_rden;
  logic [15:0]   usb_di;
  logic          usb_di_valid;
  logic          usb_di_ready;
  logic          pktend_n;
  logic          pktend_arm;
  logic [15:0]   pkt_cnt;
  logic          timeout_err;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 ifclk = ~ifclk;

  usb_pkt_sched #(.PKTEND_TIMEOUT(16)) dut (
    .ifclk        (ifclk),
    .reset        (reset),
    .enable       (enable),
    .pkt_len      (pkt_len),
    .fifo_do      (fifo_do),
    .fifo_empty   (fifo_empty),
    .fifo_rden    (fifo_rden),
    .usb_di       (usb_di),
    .usb_di_valid (usb_di_valid),
    .usb_di_ready (usb_di_ready),
    .pktend_n     (pktend_n),
    .pktend_arm   (pktend_arm),
    .pkt_cnt      (pkt_cnt),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  // FWFT FIFO model: bench pushes, DUT pops with fifo_rden
  logic [127:0] fifo_mem [0:7];
  int wr_ptr  = 0;
  int pop_cnt = 0;
  assign fifo_empty = (wr_ptr == pop_cnt);
  assign fifo_do    = fifo_mem[pop_cnt[2:0]];

  always @(posedge ifclk) if (fifo_rden) pop_cnt <= pop_cnt + 1;

  // Transfer monitor: records accepted halfwords and checks hold-under-backpressure
  logic [15:0] cap [$];
  int          cap_t [$];
  int          cyc  = 0;
  int          viol = 0;
  logic        pv   = 1'b0;
  logic [15:0] pd   = 16'd0;

  always @(posedge ifclk) begin
    cyc <= cyc + 1;
    if (reset) begin
      pv <= 1'b0;
    end else begin
      if (pv && !(usb_di_valid === 1'b1 && usb_di === pd)) viol <= viol + 1;
      if (usb_di_valid && usb_di_ready) begin
        cap.push_back(usb_di);
        cap_t.push_back(cyc);
      end
      pv <= usb_di_valid && !usb_di_ready;
      pd <= usb_di;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mkword(input int k);
    logic [127:0] w;
    for (int i = 0; i < 8; i++) w[16*i +: 16] = 16'(16'h1000 + k*16 + i);
    return w;
  endfunction

  task automatic push(input int k);
    fifo_mem[wr_ptr[2:0]] = mkword(k);
    wr_ptr++;
  endtask

  task automatic tick();
    @(posedge ifclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_cap(input int n, input string tag);
    int b = 0;
    while (cap.size() < n && b < 300) begin
      tick();
      b++;
    end
    chk(tag, 32'(cap.size() >= n), 1);
  endtask

  task automatic wait_arm(input string tag);
    int b = 0;
    while (pktend_arm !== 1'b1 && b < 300) begin
      tick();
      b++;
    end
    chk(tag, 32'(pktend_arm), 1);
  endtask

  // Halfword j of the sequence starting at word k0 is 0x1000 + word*16 + halfword index
  task automatic chk_words(input int base, input int k0, input int n, input string tag);
    int bad = 0;
    logic [15:0] e;
    for (int j = 0; j < n; j++) begin
      e = 16'(16'h1000 + (k0 + j / 8) * 16 + j % 8);
      if (base + j >= cap.size()) bad++;
      else if (cap[base + j] !== e) bad++;
    end
    chk(tag, bad, 0);
  endtask

  int base, base2, p0, v0, n, b, bad;

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    pkt_len      = 16'd0;
    usb_di_ready = 1'b0;
    pktend_n     = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_rden",   32'(fifo_rden), 0);
    chk("rst_valid",  32'(usb_di_valid), 0);
    chk("rst_arm",    32'(pktend_arm), 0);
    chk("rst_terr",   32'(timeout_err), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_di",     32'(usb_di), 0);
    chk("rst_pktcnt", 32'(pkt_cnt), 0);
    reset        = 1'b0;
    enable       = 1'b1;
    usb_di_ready = 1'b1;

    // Streaming, two words
    base = cap.size();
    p0   = pop_cnt;
    push(0);
    push(1);
    wait_cap(base + 16, "stream_wait");
    repeat (4) tick();
    chk("stream_count", cap.size() - base, 16);
    chk_words(base, 0, 16, "stream_data");
    chk("stream_gapless", cap_t[base + 15] - cap_t[base], 15);
    chk("stream_rden", pop_cnt - p0, 2);
    chk("stream_pktcnt", 32'(pkt_cnt), 0);
    chk("stream_idle", 32'(busy), 0);

    // Packets of 8, two words, PKTEND 5 cycles after arm
    do_reset();
    pkt_len = 16'd8;
    base = cap.size();
    p0   = pop_cnt;
    push(2);
    push(3);
    for (int p = 0; p < 2; p++) begin
      wait_arm("pkt8_arm");
      chk("pkt8_words_at_arm", cap.size() - base, 8 * (p + 1));
      bad = 0;
      repeat (5) begin
        if (pktend_arm !== 1'b1 || usb_di_valid !== 1'b0) bad++;
        tick();
      end
      chk("pkt8_arm_held_no_valid", bad, 0);
      pktend_n = 1'b0;
      tick();
      pktend_n = 1'b1;
      chk("pkt8_arm_drop", 32'(pktend_arm), 0);
      chk("pkt8_pktcnt", 32'(pkt_cnt), p + 1);
    end
    repeat (4) tick();
    chk("pkt8_count", cap.size() - base, 16);
    chk_words(base, 2, 16, "pkt8_data");
    chk("pkt8_rden", pop_cnt - p0, 2);

    // Packets of 3 within a single word
    do_reset();
    pkt_len = 16'd3;
    base = cap.size();
    push(4);
    for (int p = 0; p < 2; p++) begin
      wait_arm("pkt3_arm");
      chk("pkt3_words_at_arm", cap.size() - base, 3 * (p + 1));
      repeat (2) tick();
      pktend_n = 1'b0;
      tick();
      pktend_n = 1'b1;
      chk("pkt3_pktcnt", 32'(pkt_cnt), p + 1);
    end
    wait_cap(base + 8, "pkt3_tail_wait");
    repeat (3) tick();
    chk("pkt3_count", cap.size() - base, 8);
    chk_words(base, 4, 8, "pkt3_data");
    chk("pkt3_pktcnt_final", 32'(pkt_cnt), 2);
    chk("pkt3_idle", 32'(busy), 0);
    chk("pkt3_no_arm", 32'(pktend_arm), 0);

    // Backpressure, ready toggling every cycle
    do_reset();
    pkt_len = 16'd0;
    base = cap.size();
    p0   = pop_cnt;
    v0   = viol;
    push(5);
    push(6);
    b = 0;
    while (cap.size() < base + 16 && b < 300) begin
      usb_di_ready = ~usb_di_ready;
      tick();
      b++;
    end
    chk("bp_done", 32'(cap.size() >= base + 16), 1);
    usb_di_ready = 1'b1;
    repeat (3) tick();
    chk("bp_count", cap.size() - base, 16);
    chk_words(base, 5, 16, "bp_data");
    chk("bp_stable", viol - v0, 0);
    chk("bp_rden", pop_cnt - p0, 2);

    // PKTEND never arrives: timeout after 16 WAIT cycles
    do_reset();
    pkt_len = 16'd8;
    base = cap.size();
    push(7);
    wait_arm("tmo_arm");
    n = 0;
    b = 0;
    while (pktend_arm === 1'b1 && b < 100) begin
      n++;
      tick();
      b++;
    end
    chk("tmo_wait_cycles", n, 16);
    chk("tmo_err", 32'(timeout_err), 1);
    chk("tmo_pktcnt", 32'(pkt_cnt), 0);
    chk("tmo_idle", 32'(busy), 0);
    repeat (3) tick();
    chk("tmo_sticky", 32'(timeout_err), 1);
    chk_words(base, 7, 8, "tmo_data");

    // Reset in SEND at halfword 4
    do_reset();
    chk("rst2_terr_clear", 32'(timeout_err), 0);
    pkt_len = 16'd0;
    base = cap.size();
    push(8);
    push(9);
    wait_cap(base + 4, "rst2_wait4");
    #2;
    reset = 1'b1;
    #1;
    chk("rst2_async_valid", 32'(usb_di_valid), 0);
    chk("rst2_async_di",    32'(usb_di), 0);
    chk("rst2_async_busy",  32'(busy), 0);
    chk("rst2_async_rden",  32'(fifo_rden), 0);
    p0 = pop_cnt;
    tick();
    tick();
    chk("rst2_no_pop", pop_cnt - p0, 0);
    chk("rst2_partial", cap.size() - base, 4);
    reset = 1'b0;
    base2 = cap.size();
    wait_cap(base2 + 8, "rst2_next_wait");
    repeat (3) tick();
    chk_words(base2, 9, 8, "rst2_next_word");
    chk("rst2_next_count", cap.size() - base2, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_pkt_sched.md
USB_PKT_SCHED -- requirements
Module: usb_pkt_sched

Interface
REQ-001 Parameter: PKTEND_TIMEOUT, default 4096; the maximum number of WAIT cycles for PKTEND before the packet is abandoned.
REQ-002 ifclk  in  1  sole clock; all logic is rising-edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 enable  in  1  1 permits fetching new FIFO words.
REQ-005 pkt_len  in  16  packet length in 16-bit words; 0 = streaming, no packetization.
REQ-006 fifo_do  in  128  FWFT FIFO head word; valid while fifo_empty=0.
REQ-007 fifo_empty  in  1  FIFO empty flag.
REQ-008 fifo_rden  out  1  one-cycle pop pulse to the FIFO.
REQ-009 usb_di  out  16  data to ezusb_io DI.
REQ-010 usb_di_valid  out  1  DI valid.
REQ-011 usb_di_ready  in  1  ezusb_io accepts data.
REQ-012 pktend_n  in  1  observed PKTEND pin, active-low.
REQ-013 pktend_arm  out  1  to ezusb_io pktend_arm; its 0->1 edge requests PKTEND.
REQ-014 pkt_cnt  out  16  count of completed packets, wraps at 65535->0.
REQ-015 timeout_err  out  1  sticky flag; set on a PKTEND timeout.
REQ-016 busy  out  1  1 when state != IDLE.

Function
REQ-017 States SHALL be IDLE, SEND, ARM and WAIT.
REQ-018 128-bit words SHALL be emitted low halfword first: word_idx 0..7 selects bits [16*i+15:16*i].
REQ-019 A transfer occurs on any cycle with usb_di_valid=1 and usb_di_ready=1; usb_di/usb_di_valid SHALL be held stable otherwise.
REQ-020 IDLE with enable=1 and fifo_empty=0: capture fifo_do, set word_idx=0, usb_di_valid<=1, pulse fifo_rden for the next cycle, go to SEND.
REQ-021 fifo_empty SHALL be ignored in the cycle fifo_rden=1 (stale flag).
REQ-022 Each transfer SHALL increment word_idx mod 8 and the in-packet word count.
REQ-023 A packet ends when pkt_len != 0 and the in-packet count reaches the latched length.
  - The block then goes to ARM and drops usb_di_valid.
  - Packet end has priority over word refill.
REQ-024 After the transfer of word_idx=7, with no packet end:
  - enable=1 and fifo_empty=0: capture the next word, pulse fifo_rden, keep usb_di_valid=1 (no bubble).
  - Otherwise: usb_di_valid<=0 and go to IDLE.
REQ-025 A packet may end mid-word; the remaining halfwords of that word SHALL be sent first in the next packet.
REQ-026 enable=0 SHALL only block fetching new words; the current word drains completely.
REQ-027 ARM: pktend_arm<=1, clear the timeout counter, go to WAIT; pktend_arm is 0 in all other states except WAIT.
REQ-028 WAIT, on pktend_n=0 sampled:
  - pktend_arm<=0, pkt_cnt+1, in-packet count<=0.
  - Go to SEND with usb_di_valid<=1 if the word is unfinished, else to IDLE.
REQ-029 WAIT with the counter reaching PKTEND_TIMEOUT: timeout_err<=1, then take the same exit as REQ-028 but without incrementing pkt_cnt.
REQ-030 pkt_len SHALL be latched whenever the in-packet count is 0 and a packet's first transfer occurs; later changes to pkt_len do not affect the current packet.
REQ-031 pkt_len=0 SHALL never enter ARM, and pkt_cnt SHALL stay unchanged.
REQ-032 In-packet count SHALL be 16 bits; pkt_len=65535 SHALL be supported without overflow.

Reset
REQ-033 Reset SHALL force:
  - state=IDLE;
  - fifo_rden, usb_di_valid, pktend_arm, timeout_err and busy = 0;
  - usb_di, pkt_cnt, word_idx, in-packet count and timeout counter = 0.
REQ-034 Reset mid-packet SHALL discard the buffered word without a FIFO pop.
REQ-035 The first rden after reset release SHALL follow REQ-020.

Structure
REQ-036 State encoding and the default PKTEND_TIMEOUT SHALL reside in a shared package, memfifo_pkg.
REQ-037 One sub-module, usb_word_unpack (128->16 shift register with word_idx), is natural; the FSM stays in usb_pkt_sched.

Verification
REQ-038 Streaming: pkt_len=0, 2 FIFO words, ready=1 -> 16 consecutive halfwords in order, 2 rden pulses, pkt_cnt=0.
REQ-039 Packet: pkt_len=8, 2 words, pktend_n low 5 cycles after arm -> 8 halfwords, valid gap, arm high until PKTEND, pkt_cnt=2.
REQ-040 Mid-word end: pkt_len=3, 1 word -> packets of 3, 3 and 2 halfwords (the last, with FIFO empty, sent, then IDLE); pkt_cnt=2.
REQ-041 Backpressure: ready toggles 1/0 each cycle -> usb_di stable while ready=0, no word lost or duplicated.
REQ-042 Timeout: PKTEND_TIMEOUT=16, pktend_n held 1 -> timeout_err=1 after 16 WAIT cycles, pkt_cnt unchanged, state returns to IDLE.
REQ-043 Reset asserted during SEND word_idx=4 -> all outputs 0 asynchronously, no rden; after release, the next FIFO word starts at halfword 0.
